// File: rtl/ff_bank_arbiter.sv
// Round-robin write arbiter for a shared flip-flop register bank.
// Each ownership is capped at MAX_HOLD consecutive writes before the grant rotates.
module ff_bank_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic                       bank_en,
  output logic [WIDTH-1:0]           bank_d
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam int unsigned HW = 8;

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [OW-1:0]     owner_d;
  logic              busy_d;
  logic [OW-1:0]     rr_ptr, rr_ptr_d;
  logic [HW-1:0]     hold_cnt, hold_cnt_d;

  logic              own_req;
  logic              release_c;
  logic [OW-1:0]     scan_base;
  logic [N_REQ-1:0]  req_rot;
  logic              win_vld;
  logic [OW-1:0]     win_idx;
  int unsigned       win_sum;

  // gnt is one-hot on owner, so masking req with it yields the owner's request.
  assign own_req = |(req & gnt);
  assign bank_en = (state_q == GRANT) && own_req && !rst;

  // On release the scan starts just past the owner, so the owner is considered last.
  always_comb begin
    if (state_q == GRANT) begin
      scan_base = (32'(owner) == N_REQ - 1) ? '0 : OW'(32'(owner) + 1);
    end else begin
      scan_base = rr_ptr;
    end
  end

  // First requester at or after scan_base, modulo N_REQ.
  always_comb begin
    req_rot = N_REQ'({req, req} >> scan_base);
    win_vld = 1'b0;
    win_idx = '0;
    win_sum = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_vld && req_rot[k]) begin
        win_vld = 1'b1;
        win_sum = 32'(scan_base) + 32'(k);
        if (win_sum >= N_REQ) win_sum = win_sum - N_REQ;
        win_idx = OW'(win_sum);
      end
    end
  end

  always_comb begin
    bank_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bank_en && gnt[i]) bank_d = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      owner    <= owner_d;
      busy     <= busy_d;
      rr_ptr   <= rr_ptr_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt;
    owner_d    = owner;
    busy_d     = busy;
    rr_ptr_d   = rr_ptr;
    hold_cnt_d = hold_cnt;
    release_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d    = GRANT;
          gnt_d      = N_REQ'(1) << win_idx;
          owner_d    = win_idx;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        release_c = !own_req || (hold_cnt == HW'(MAX_HOLD - 1));
        if (!release_c) begin
          hold_cnt_d = hold_cnt + HW'(1);
        end else begin
          rr_ptr_d = scan_base;
          if (win_vld) begin
            gnt_d      = N_REQ'(1) << win_idx;
            owner_d    = win_idx;
            hold_cnt_d = '0;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            owner_d    = '0;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Directed bench for ff_bank_arbiter: per-cycle vector table on a MAX_HOLD=4 instance,
// plus a full-contention rotation sequence on a MAX_HOLD=2 instance.
module tb_ff_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;

  logic [3:0] h4_gnt, h2_gnt;
  logic [1:0] h4_owner, h2_owner;
  logic       h4_busy, h2_busy, h4_en, h2_en;
  logic [7:0] h4_d, h2_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(h4_gnt), .owner(h4_owner), .busy(h4_busy), .bank_en(h4_en), .bank_d(h4_d)
  );

  ff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(h2_gnt), .owner(h2_owner), .busy(h2_busy), .bank_en(h2_en), .bank_d(h2_d)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       en;
    logic [7:0] d;
  } vec_t;

  localparam int NV = 37;
  vec_t vt [NV];
  logic [7:0] wd [4];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] o, input logic b, input logic e,
                              input logic [7:0] d);
    vec_t v;
    v.rst = r; v.req = q; v.gnt = g; v.owner = o; v.busy = b; v.en = e; v.d = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_inv();
    chk("h4_gnt_onehot0", 32'($onehot0(h4_gnt)), 32'd1);
    chk("h2_gnt_onehot0", 32'($onehot0(h2_gnt)), 32'd1);
    chk("h4_en_implies_busy", 32'(!h4_en || h4_busy), 32'd1);
    chk("h2_en_implies_busy", 32'(!h2_en || h2_busy), 32'd1);
  endtask

  initial begin
    wd[0] = 8'hA5; wd[1] = 8'hB1; wd[2] = 8'hC2; wd[3] = 8'hD3;
    wdata = {wd[3], wd[2], wd[1], wd[0]};

    // rst, req, gnt, owner, busy, en, d -- outputs observed during the same cycle
    vt[0]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 8'h00);
    vt[1]  = mk(0, 4'h1, 4'h0, 0, 0, 0, 8'h00);
    vt[2]  = mk(0, 4'h1, 4'h1, 0, 1, 1, 8'hA5);
    vt[3]  = mk(0, 4'h1, 4'h1, 0, 1, 1, 8'hA5);
    vt[4]  = mk(0, 4'h1, 4'h1, 0, 1, 1, 8'hA5);
    vt[5]  = mk(0, 4'h1, 4'h1, 0, 1, 1, 8'hA5);
    vt[6]  = mk(0, 4'h1, 4'h1, 0, 1, 1, 8'hA5);
    vt[7]  = mk(0, 4'h0, 4'h1, 0, 1, 0, 8'h00);
    vt[8]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 8'h00);
    vt[9]  = mk(0, 4'h2, 4'h0, 0, 0, 0, 8'h00);
    vt[10] = mk(0, 4'h2, 4'h2, 1, 1, 1, 8'hB1);
    vt[11] = mk(0, 4'h8, 4'h2, 1, 1, 0, 8'h00);
    vt[12] = mk(0, 4'h8, 4'h8, 3, 1, 1, 8'hD3);
    vt[13] = mk(0, 4'h8, 4'h8, 3, 1, 1, 8'hD3);
    vt[14] = mk(0, 4'h8, 4'h8, 3, 1, 1, 8'hD3);
    vt[15] = mk(0, 4'h8, 4'h8, 3, 1, 1, 8'hD3);
    vt[16] = mk(0, 4'h8, 4'h8, 3, 1, 1, 8'hD3);
    vt[17] = mk(0, 4'h9, 4'h8, 3, 1, 1, 8'hD3);
    vt[18] = mk(0, 4'h9, 4'h8, 3, 1, 1, 8'hD3);
    vt[19] = mk(0, 4'h9, 4'h8, 3, 1, 1, 8'hD3);
    vt[20] = mk(0, 4'h9, 4'h1, 0, 1, 1, 8'hA5);
    vt[21] = mk(0, 4'h0, 4'h1, 0, 1, 0, 8'h00);
    vt[22] = mk(0, 4'h4, 4'h0, 0, 0, 0, 8'h00);
    vt[23] = mk(0, 4'h4, 4'h4, 2, 1, 1, 8'hC2);
    vt[24] = mk(0, 4'h0, 4'h4, 2, 1, 0, 8'h00);
    vt[25] = mk(0, 4'h9, 4'h0, 0, 0, 0, 8'h00);
    vt[26] = mk(0, 4'h9, 4'h8, 3, 1, 1, 8'hD3);
    vt[27] = mk(0, 4'h1, 4'h8, 3, 1, 0, 8'h00);
    vt[28] = mk(0, 4'h1, 4'h1, 0, 1, 1, 8'hA5);
    vt[29] = mk(0, 4'h0, 4'h1, 0, 1, 0, 8'h00);
    vt[30] = mk(0, 4'h4, 4'h0, 0, 0, 0, 8'h00);
    vt[31] = mk(0, 4'h4, 4'h4, 2, 1, 1, 8'hC2);
    vt[32] = mk(1, 4'h4, 4'h4, 2, 1, 0, 8'h00);
    vt[33] = mk(0, 4'h4, 4'h0, 0, 0, 0, 8'h00);
    vt[34] = mk(0, 4'h4, 4'h4, 2, 1, 1, 8'hC2);
    vt[35] = mk(0, 4'h0, 4'h4, 2, 1, 0, 8'h00);
    vt[36] = mk(0, 4'h0, 4'h0, 0, 0, 0, 8'h00);

    rst = 1'b1;
    req = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("idle%0d_gnt", i),   32'(h4_gnt),   32'd0);
      chk($sformatf("idle%0d_busy", i),  32'(h4_busy),  32'd0);
      chk($sformatf("idle%0d_en", i),    32'(h4_en),    32'd0);
      chk($sformatf("idle%0d_owner", i), 32'(h4_owner), 32'd0);
      chk_inv();
      @(negedge clk);
    end

    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst;
      req = vt[i].req;
      #1;
      chk($sformatf("row%0d_gnt", i),   32'(h4_gnt),   32'(vt[i].gnt));
      chk($sformatf("row%0d_owner", i), 32'(h4_owner), 32'(vt[i].owner));
      chk($sformatf("row%0d_busy", i),  32'(h4_busy),  32'(vt[i].busy));
      chk($sformatf("row%0d_en", i),    32'(h4_en),    32'(vt[i].en));
      chk($sformatf("row%0d_d", i),     32'(h4_d),     32'(vt[i].d));
      chk_inv();
      @(negedge clk);
    end

    // Full contention with MAX_HOLD=2: two writes per owner, rotating 0..3 and wrapping.
    rst = 1'b1;
    req = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req = 4'hF;
    #1;
    chk("rot_first_gnt", 32'(h2_gnt), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      int o;
      o = (k / 2) % 4;
      #1;
      chk($sformatf("rot%0d_owner", k), 32'(h2_owner), 32'(o));
      chk($sformatf("rot%0d_gnt", k),   32'(h2_gnt),   32'(1 << o));
      chk($sformatf("rot%0d_en", k),    32'(h2_en),    32'd1);
      chk($sformatf("rot%0d_d", k),     32'(h2_d),     32'(wd[o]));
      chk_inv();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ff_bank_arbiter.md
Name: ff_bank_arbiter

Overview:
- Round-robin write arbiter that shares one WIDTH-bit register bank, built from enable/reset flip-flop cells, among N_REQ requesters.
- Drives the bank's enable and data inputs.
- Limits each owner to MAX_HOLD consecutive write cycles so no requester can starve the others.
- Sits between requester logic and the shared flip-flop bank; the bank itself is outside this block.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, data width of the shared register bank
MAX_HOLD, 4, max consecutive granted cycles per ownership (1..255)

Ports:
clk  in  1  rising-edge clock, the single clock domain
rst  in  1  synchronous reset, active-high
req  in  N_REQ  per-requester write request, level; held high while it wants to write
wdata  in  N_REQ*WIDTH  per-requester write data; requester i uses bits [i*WIDTH +: WIDTH]
gnt  out  N_REQ  registered one-hot grant; all zero when idle
owner  out  $clog2(N_REQ)  index of current grantee; 0 when idle
busy  out  1  high while any grant is held (state GRANT)
bank_en  out  1  enable to the flip-flop bank
bank_d  out  WIDTH  data to the flip-flop bank

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge.
- Reset values: state=IDLE, gnt=0, owner=0, busy=0, rr_ptr=0, hold_cnt=0. bank_en=0 and bank_d=0 from the first post-reset edge.
- rst overrides everything, including mid-ownership. The write in the reset cycle is suppressed: bank_en=0 that cycle.
- Winner selection: first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
- States: IDLE, GRANT.
- IDLE:
  - If any req bit is high, the next edge loads gnt=onehot(winner), owner=winner, hold_cnt=0, and moves to GRANT.
  - Otherwise stay in IDLE.
  - Grant latency: 1 cycle from req rising to gnt high.
- GRANT, write cycle:
  - bank_en = req[owner], combinational from registered gnt and live req.
  - bank_d = wdata slice of owner when bank_en=1; 0 otherwise.
  - Each cycle with bank_en=1 increments hold_cnt.
- GRANT, release conditions:
  - (a) req[owner]=0. No write occurs that cycle.
  - (b) The write cycle where hold_cnt reaches MAX_HOLD-1, i.e. the MAX_HOLD-th write is performed, then release.
- On release:
  - rr_ptr = owner+1 modulo N_REQ.
  - The winner is recomputed from the current req using the new pointer.
  - If a winner exists, the next edge re-grants with no idle cycle and hold_cnt=0. Otherwise go to IDLE with gnt=0.
  - The releasing owner may re-win only if no other req bit is high.
- Requests and grants:
  - Non-owner req changes during GRANT do not affect the grant until release.
  - A requester dropping req while not granted is simply skipped.
- Invariants:
  - gnt is never multi-hot.
  - bank_en=1 implies busy=1.
  - MAX_HOLD=1 gives strict per-cycle round-robin.
  - owner wraps from N_REQ-1 to 0.

Test Plan:
- Reset then idle: rst high 2 cycles, req=0 → gnt=0, busy=0, bank_en=0, owner=0 for 10 cycles.
- Single requester, N_REQ=4, MAX_HOLD=4:
  - Stimulus: req=0001 held, wdata0=0xA5.
  - Response: gnt=0001 one cycle later; bank_en high 4 cycles with bank_d=0xA5.
  - Then release and an immediate re-grant to 0, since no others request; gnt stays 0001 with no gap.
- Contention rotation: req=1111 constant, MAX_HOLD=2 → owner sequence 0,0,1,1,2,2,3,3,0,0…; bank_en continuously 1.
- Early release: owner 1 holds; req[1] drops after 1 write while req[3] is high → one cycle with bank_en=0, then gnt=1000 next edge; rr_ptr=2.
- Wrap-around: rr_ptr=3 and req=1001 → grant 3 first; after release, grant 0.
- Reset mid-ownership: owner=2 with hold_cnt=1; assert rst one cycle → bank_en=0 that cycle; next cycle gnt=0, rr_ptr=0. With req=0100 still high, re-grant to 2 one cycle after rst drops.
